holy_timer_irq: RTL and testbench
=================================

# holy_timer_irq

Programmable countdown timer peripheral on the SoC AXI-lite bus. It drives one interrupt line into an `irq_in` bit of the platform interrupt controller. Software sets a reload value, a prescaler and a mode. On each expiry the block raises a sticky expired flag, and `irq_o` follows that flag while interrupts are enabled. Because the controller latches edges until they are claimed, software must clear the flag (W1C) before completing the claim.

## Interface
- `BASE_ADDR`, default 0: bus base address, subtracted from `awaddr`/`araddr` before decode.
- `PRESCALE_W`, default 16: width of the prescaler register and counter (1..32).
- `clk` in 1: the single SoC/AXI clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `s_axi_lite` slave `axi_lite_if`: 32-bit AXI-lite register port. `wstrb` is ignored.
- `irq_o` out 1: level interrupt to the controller; equals `STATUS.expired & CTRL.irq_en`.

## Operation
Register map (byte offsets):
- `0x00 CTRL` (reset 0): bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`. All other bits read as 0.
- `0x04 LOAD` (reset 0): 32-bit reload value.
- `0x08 COUNT` (reset 0): current count. Reads return the live value; a write sets it directly.
- `0x0C STATUS` (reset 0): bit0 `expired`. Writing 1 clears it; writing 0 has no effect.
- `0x10 PRESCALE` (reset 0): prescaler divide value. Zero-extended on read; upper bits are ignored on write.

Counting, while `en`=1:
- The prescaler counter runs 0..PRESCALE and emits a one-cycle `tick` when it equals PRESCALE, then wraps to 0.
- On a tick with COUNT≠0: COUNT decrements by 1.
- On a tick with COUNT=0: set `expired`. If `auto_reload`=1, COUNT←LOAD. If `auto_reload`=0, COUNT stays 0 and `en` clears (one-shot).
- While `en`=0: the prescaler holds at 0 and COUNT holds.
- A write to CTRL that takes `en` from 0 to 1 clears the prescaler counter.
- COUNT is 32-bit unsigned. The decrement never wraps, because zero is handled as expiry.

Bus FSM states: `SLAVE_IDLE`, `LITE_SENDING_READ_DATA`, `LITE_RECEIVING_WRITE_DATA`, `LITE_SENDING_WRITE_RES`.
- `SLAVE_IDLE`: `awready`=`arready`=1.
  - `arvalid` latches `araddr-BASE_ADDR` and goes to READ.
  - `awvalid` latches `awaddr-BASE_ADDR` and goes to WRITE_DATA.
  - If both are valid in the same cycle, the write wins.
- `LITE_SENDING_READ_DATA`: `rvalid`=1 with data decoded from the latched address. Returns to IDLE on `rready`.
- `LITE_RECEIVING_WRITE_DATA`: `wready`=1. On `wvalid` the write is performed and the FSM goes to WRITE_RES.
- `LITE_SENDING_WRITE_RES`: `bvalid`=1. Returns to IDLE on `bready`.

Responses:
- Read of an unmapped offset: `rresp`=2'b11, `rdata`=32'hAEAEAEAE.
- Write to an unmapped offset: no state change, `bresp`=2'b10.
- Mapped accesses return OKAY (2'b00).

Simultaneous events:
- Expiry and a STATUS W1C in the same cycle: expiry wins and `expired` stays 1.
- COUNT write and a tick in the same cycle: the write wins, and the prescaler counter clears.
- CTRL write and a one-shot auto-clear of `en` in the same cycle: the CTRL write wins.

## Timing
- Reset values:
  - All registers are 0 and the FSM is in `SLAVE_IDLE`.
  - `irq_o`=0, `rvalid`=`bvalid`=`wready`=0, `rresp`=`bresp`=0, `rdata`=0.
  - `awready`=`arready`=1 from the first cycle after reset.
- Reset asserted mid-transaction drops the handshake immediately and returns the FSM to IDLE. No write is performed.
- Read: address accepted in cycle T, `rvalid` in T+1, held until `rready`.
- Write: address accepted in T, `wready` from T+1. Register update on the `wvalid` cycle W; `bvalid` from W+1.
- Expiry period with auto-reload: (LOAD+1)×(PRESCALE+1) cycles.
- `expired` and `irq_o` rise in the cycle after the expiring tick.
- A STATUS clear drops `irq_o` in the cycle after the accepted write beat.

## Configuration
- `HOLY_TIMER_PRESCALER_EN` defined: the prescaler is present as described above.
- Not defined: the prescaler is omitted and `tick`=1 every cycle while `en`=1. PRESCALE reads 0, writes to it are accepted with OKAY and ignored, and the period is LOAD+1 cycles.

## Test plan
- Reset, then read all five registers: every read returns 0 with `rresp`=0, and `irq_o`=0.
- LOAD=3, PRESCALE=1, CTRL=0b111, and no STATUS clear between expiries: `irq_o` first rises 8 cycles after `en`. STATUS reads 1 at each expiry, every 8 cycles.
- One-shot: COUNT=2, PRESCALE=0, CTRL=0b101. `irq_o` rises 3 cycles after `en`. CTRL then reads 0b100 and COUNT holds 0.
- W1C STATUS=1 while `irq_o`=1 and the timer is idle: `irq_o` is 0 on the cycle after the write beat. The same write landing on an expiry cycle leaves STATUS at 1.
- Read offset 0x20: `rresp`=3 with 0xAEAEAEAE. Write 0x20: `bresp`=2 and no register changes.
- `awvalid` and `arvalid` asserted together in IDLE: the write completes first, and the read is accepted afterwards when re-presented.

Source files
------------

// File: rtl/holy_timer_irq_if.sv
// AXI-lite register port bundle for holy_timer_irq.
// 32-bit address/data; master drives requests, slave returns handshakes.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/holy_timer_irq.sv
// Countdown timer with sticky expiry flag and level irq, AXI-lite regs.
// Ports: clk, rst (sync, active-high), s_axi_lite (slave), irq_o.
// Build option: HOLY_TIMER_PRESCALER_EN adds the tick prescaler.
module holy_timer_irq #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    axi_lite_if.slave   s_axi_lite,
    output logic        irq_o
);
    localparam logic [1:0] SLAVE_IDLE                = 2'd0;
    localparam logic [1:0] LITE_SENDING_READ_DATA    = 2'd1;
    localparam logic [1:0] LITE_RECEIVING_WRITE_DATA = 2'd2;
    localparam logic [1:0] LITE_SENDING_WRITE_RES    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irqen_q, irqen_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;

    logic        sel_ctrl, sel_load, sel_count, sel_stat, sel_pre;
    logic        mapped, wr_fire, tick, expire;
    logic [31:0] wd, rd_data, pre_rd;

    assign wd = s_axi_lite.wdata;

    // Handshakes drop in the reset cycle itself, not one edge later.
    assign s_axi_lite.awready = (state_q == SLAVE_IDLE) && !rst;
    assign s_axi_lite.arready = (state_q == SLAVE_IDLE) && !rst;
    assign s_axi_lite.rvalid  =
        (state_q == LITE_SENDING_READ_DATA) && !rst;
    assign s_axi_lite.wready  =
        (state_q == LITE_RECEIVING_WRITE_DATA) && !rst;
    assign s_axi_lite.bvalid  =
        (state_q == LITE_SENDING_WRITE_RES) && !rst;

    assign sel_ctrl  = (addr_q == 32'h00);
    assign sel_load  = (addr_q == 32'h04);
    assign sel_count = (addr_q == 32'h08);
    assign sel_stat  = (addr_q == 32'h0C);
    assign sel_pre   = (addr_q == 32'h10);
    assign mapped    = sel_ctrl | sel_load | sel_count
                     | sel_stat | sel_pre;

    assign wr_fire = s_axi_lite.wready && s_axi_lite.wvalid;

`ifdef HOLY_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;

    assign tick   = en_q && (psc_q == pre_q);
    assign pre_rd = 32'(pre_q);

    always_comb begin
        pre_d = pre_q;
        if (wr_fire && sel_pre) pre_d = wd[PRESCALE_W-1:0];
        if (!en_q || tick) psc_d = '0;
        else               psc_d = psc_q + 1'b1;
        // COUNT writes and a fresh enable restart the divide window.
        if (wr_fire && sel_count) psc_d = '0;
        if (wr_fire && sel_ctrl && wd[0] && !en_q) psc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            psc_q <= '0;
        end else begin
            pre_q <= pre_d;
            psc_q <= psc_d;
        end
    end
`else
    assign tick   = en_q;
    assign pre_rd = 32'h0;
`endif

    assign expire = tick && (count_q == 32'h0);

    always_comb begin
        rd_data = 32'h0;
        unique case (1'b1)
            sel_ctrl:  rd_data = {29'h0, irqen_q, auto_q, en_q};
            sel_load:  rd_data = load_q;
            sel_count: rd_data = count_q;
            sel_stat:  rd_data = {31'h0, expired_q};
            sel_pre:   rd_data = pre_rd;
            default:   rd_data = 32'hAEAEAEAE;
        endcase
    end

    assign s_axi_lite.rdata = s_axi_lite.rvalid ? rd_data : 32'h0;
    assign s_axi_lite.rresp =
        (s_axi_lite.rvalid && !mapped) ? 2'b11 : 2'b00;
    assign s_axi_lite.bresp = s_axi_lite.bvalid ? bresp_q : 2'b00;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bresp_d = bresp_q;
        case (state_q)
            SLAVE_IDLE: begin
                if (s_axi_lite.awvalid) begin
                    addr_d  = s_axi_lite.awaddr - BASE_ADDR;
                    state_d = LITE_RECEIVING_WRITE_DATA;
                end else if (s_axi_lite.arvalid) begin
                    addr_d  = s_axi_lite.araddr - BASE_ADDR;
                    state_d = LITE_SENDING_READ_DATA;
                end
            end
            LITE_SENDING_READ_DATA:
                if (s_axi_lite.rready) state_d = SLAVE_IDLE;
            LITE_RECEIVING_WRITE_DATA:
                if (s_axi_lite.wvalid) begin
                    bresp_d = mapped ? 2'b00 : 2'b10;
                    state_d = LITE_SENDING_WRITE_RES;
                end
            default:
                if (s_axi_lite.bready) state_d = SLAVE_IDLE;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        irqen_d   = irqen_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        if (expire && !auto_q) en_d = 1'b0;
        if (wr_fire && sel_ctrl) begin
            en_d    = wd[0];
            auto_d  = wd[1];
            irqen_d = wd[2];
        end
        if (wr_fire && sel_load) load_d = wd;
        if (wr_fire && sel_count) count_d = wd;
        else if (expire)          count_d = auto_q ? load_q : 32'h0;
        else if (tick)            count_d = count_q - 32'd1;
        if (expire) expired_d = 1'b1;
        else if (wr_fire && sel_stat && wd[0]) expired_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SLAVE_IDLE;
            addr_q    <= 32'h0;
            bresp_q   <= 2'b00;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            irqen_q   <= 1'b0;
            load_q    <= 32'h0;
            count_q   <= 32'h0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bresp_q   <= bresp_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            irqen_q   <= irqen_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign irq_o = expired_q & irqen_q;
endmodule

// File: tb/tb_holy_timer_irq.sv
// Self-checking bench for holy_timer_irq: register vectors,
// timing corner sequences and randomized expiry timing vs a model.
module tb_holy_timer_irq;
`ifdef HOLY_TIMER_PRESCALER_EN
    localparam bit PSEN = 1'b1;
`else
    localparam bit PSEN = 1'b0;
`endif
    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_LOAD = 32'h04;
    localparam logic [31:0] A_CNT  = 32'h08;
    localparam logic [31:0] A_STAT = 32'h0C;
    localparam logic [31:0] A_PRE  = 32'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq_o;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    logic irq_e;

    axi_lite_if bus();

    holy_timer_irq dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi_lite (bus.slave),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        ncmp++;
        nfail++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input int at, output logic [1:0] resp,
                             output int e);
        int n;
        @(posedge clk); #1;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.awready && n < 50);
        if (!bus.awready) tmo("aw");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        while (cyc < at) begin @(posedge clk); #1; end
        bus.wdata  = d;
        bus.wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.wready && n < 50);
        if (!bus.wready) tmo("w");
        @(posedge clk); #1;
        e = cyc;
        irq_e = irq_o;
        bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.bvalid && n < 50);
        if (!bus.bvalid) tmo("b");
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a,
                            output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.arready && n < 50);
        if (!bus.arready) tmo("ar");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.rvalid && n < 50);
        if (!bus.rvalid) tmo("r");
        d    = bus.rdata;
        resp = bus.rresp;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    logic [1:0]  tr;
    logic [31:0] td;
    int          te;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_write(a, d, 0, tr, te);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        bus_read(a, td, tr);
        chk(nm, td, exp);
    endtask

    task automatic wait_rise(output int c);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!irq_o && n < 3000);
        if (!irq_o) tmo("irq rise");
        c = cyc;
    endtask

    task automatic prep(input logic [31:0] ld, input logic [31:0] cnt,
                        input logic [31:0] pre);
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_PRE, pre);
        wr(A_LOAD, ld);
        wr(A_CNT, cnt);
    endtask

    // Expiry timing model: every tick takes (P+1) cycles when the
    // prescaler exists, one cycle otherwise; N ticks to reach expiry.
    function automatic int ticks_to_cycles(input int nticks,
                                           input int pre);
        return nticks * (PSEN ? (pre + 1) : 1);
    endfunction

    initial begin
        int r1, r2, e0, c, p, ld, cnt, pre;
        bit au;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = 4'hF; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        tv.push_back('{0, A_CTRL, 0, 2'b00, 32'h0});
        tv.push_back('{0, A_LOAD, 0, 2'b00, 32'h0});
        tv.push_back('{0, A_CNT,  0, 2'b00, 32'h0});
        tv.push_back('{0, A_STAT, 0, 2'b00, 32'h0});
        tv.push_back('{0, A_PRE,  0, 2'b00, 32'h0});
        tv.push_back('{0, 32'h20, 0, 2'b11, 32'hAEAEAEAE});
        tv.push_back('{1, A_LOAD, 32'h12345678, 2'b00, 0});
        tv.push_back('{1, 32'h20, 32'hFFFFFFFF, 2'b10, 0});
        tv.push_back('{0, A_LOAD, 0, 2'b00, 32'h12345678});
        tv.push_back('{0, A_CTRL, 0, 2'b00, 32'h0});
        tv.push_back('{1, A_CTRL, 32'hFFFFFFFA, 2'b00, 0});
        tv.push_back('{0, A_CTRL, 0, 2'b00, 32'h2});
        tv.push_back('{1, A_PRE, 32'hFFFF0005, 2'b00, 0});
        tv.push_back('{0, A_PRE, 0, 2'b00, PSEN ? 32'h5 : 32'h0});
        tv.push_back('{1, A_CNT, 32'h7, 2'b00, 0});
        tv.push_back('{0, A_CNT, 0, 2'b00, 32'h7});
        tv.push_back('{1, A_STAT, 32'h0, 2'b00, 0});
        tv.push_back('{0, A_STAT, 0, 2'b00, 32'h0});
        tv.push_back('{1, A_CTRL, 32'h0, 2'b00, 0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst irq_o", {31'h0, irq_o}, 32'h0);
        chk("rst valids",
            {29'h0, bus.rvalid, bus.bvalid, bus.wready}, 32'h0);
        chk("rst rdata", bus.rdata, 32'h0);
        chk("rst resps", {28'h0, bus.rresp, bus.bresp}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle ready", {30'h0, bus.awready, bus.arready}, 32'h3);

        foreach (tv[i]) begin
            if (tv[i].wr) begin
                wr(tv[i].addr, tv[i].data);
                chk($sformatf("vec%0d bresp", i), {30'h0, tr},
                    {30'h0, tv[i].resp});
            end else begin
                bus_read(tv[i].addr, td, tr);
                chk($sformatf("vec%0d rresp", i), {30'h0, tr},
                    {30'h0, tv[i].resp});
                chk($sformatf("vec%0d rdata", i), td, tv[i].rdata);
            end
        end

        // Periodic: LOAD=COUNT=3, PRESCALE=1.
        prep(3, 3, 1);
        bus_write(A_CTRL, 32'h7, 0, tr, e0);
        wait_rise(r1);
        chk("periodic first rise", r1, e0 + ticks_to_cycles(4, 1));
        rd_chk("periodic status", A_STAT, 32'h1);
        chk("periodic irq held", {31'h0, irq_o}, 32'h1);

        // One-shot: COUNT=2, PRESCALE=0, CTRL=en|irq_en.
        prep(0, 2, 0);
        bus_write(A_CTRL, 32'h5, 0, tr, e0);
        wait_rise(r1);
        chk("oneshot rise", r1, e0 + 3);
        rd_chk("oneshot ctrl", A_CTRL, 32'h4);
        rd_chk("oneshot count", A_CNT, 32'h0);

        // W1C: plain clear, then a clear landing on an expiry tick.
        prep(9, 9, 1);
        p = ticks_to_cycles(10, 1);
        bus_write(A_CTRL, 32'h7, 0, tr, e0);
        wait_rise(r1);
        chk("w1c first rise", r1, e0 + p);
        wr(A_STAT, 32'h1);
        chk("w1c irq drop", {31'h0, irq_e}, 32'h0);
        bus_write(A_STAT, 32'h1, r1 + 2 * p - 1, tr, c);
        chk("w1c beat cycle", c, r1 + 2 * p);
        chk("w1c vs expiry irq", {31'h0, irq_e}, 32'h1);
        rd_chk("w1c vs expiry status", A_STAT, 32'h1);

        // Simultaneous aw/ar: the write goes first.
        wr(A_CTRL, 32'h0);
        @(posedge clk); #1;
        bus.awaddr = A_LOAD; bus.awvalid = 1'b1;
        bus.araddr = A_CNT;  bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        chk("both valid", {30'h0, bus.wready, bus.rvalid}, 32'h2);
        @(posedge clk); #1;
        bus.wdata = 32'h55; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.bready = 1'b1;
        @(negedge clk);
        chk("both bvalid", {31'h0, bus.bvalid}, 32'h1);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        rd_chk("both load", A_LOAD, 32'h55);

        // Randomized expiry timing against the arithmetic model.
        for (int k = 0; k < 8; k++) begin
            cnt = $urandom_range(6, 0);
            pre = $urandom_range(3, 0);
            ld  = $urandom_range(9, 4);
            au  = 1'($urandom_range(1, 0));
            prep(ld, cnt, pre);
            bus_write(A_CTRL, {29'h0, 1'b1, au, 1'b1}, 0, tr, e0);
            wait_rise(r1);
            chk($sformatf("rnd%0d rise", k), r1,
                e0 + ticks_to_cycles(cnt + 1, pre));
            if (au) begin
                wr(A_STAT, 32'h1);
                chk($sformatf("rnd%0d clr", k), {31'h0, irq_e}, 32'h0);
                wait_rise(r2);
                chk($sformatf("rnd%0d period", k), r2 - r1,
                    ticks_to_cycles(ld + 1, pre));
            end else begin
                rd_chk($sformatf("rnd%0d ctrl", k), A_CTRL, 32'h4);
                rd_chk($sformatf("rnd%0d count", k), A_CNT, 32'h0);
            end
        end

        // Reset in the middle of a write: handshake drops at once.
        wr(A_CTRL, 32'h0);
        @(posedge clk); #1;
        bus.awaddr = A_LOAD; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wdata = 32'hDEAD; bus.wvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst wready", {31'h0, bus.wready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        chk("midrst idle", {30'h0, bus.awready, bus.arready}, 32'h3);
        rd_chk("midrst load", A_LOAD, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global: simulation time limit reached");
        $fatal(1);
    end
endmodule
